// File: rtl/rv_core_pkg.sv
// Shared core parameters and types for the integer register file.
package rv_core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wr_decode32.sv
// 5-to-32 one-hot write-enable decoder; bit i = (addr == i) & en.
module wr_decode32
    import rv_core_pkg::*;
(
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [NREG-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NREG; i++) begin
            mask[i] = (addr == reg_addr_t'(i)) & en;
        end
    end

endmodule

// File: rtl/regfile_wb_bank.sv
// 32x32 register file with a one-cycle staged write port and two bypassing read ports.
module regfile_wb_bank #(
    parameter int unsigned XLEN = rv_core_pkg::XLEN,
    parameter int unsigned NREG = rv_core_pkg::NREG,
    parameter int unsigned AW   = rv_core_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wr_pending
);

    logic            st_valid_d, st_valid_q;
    logic [AW-1:0]   st_rd_q;
    logic [XLEN-1:0] st_data_q;
    logic [NREG-1:0] we_mask;
    logic [XLEN-1:0] regs_q [NREG];

    // x0 writes are dropped here so the stage never targets x0.
    assign st_valid_d = wb_we && (wb_rd != rv_core_pkg::REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid_q <= 1'b0;
            st_rd_q    <= '0;
            st_data_q  <= '0;
        end else begin
            st_valid_q <= st_valid_d;
            st_rd_q    <= wb_rd;
            st_data_q  <= wb_data;
        end
    end

    wr_decode32 u_wr_decode32 (
        .addr (st_rd_q),
        .en   (st_valid_q),
        .mask (we_mask)
    );

    // Entry 0 exists but its enable can never be set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we_mask[i]) begin
                    regs_q[i] <= st_data_q;
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] arr_word,
        input logic            st_valid,
        input logic [AW-1:0]   st_rd,
        input logic [XLEN-1:0] st_data
    );
        if (addr == rv_core_pkg::REG_ZERO) begin
            return '0;
        end else if (st_valid && (addr == st_rd)) begin
            return st_data;
        end else begin
            return arr_word;
        end
    endfunction

    assign rs1_data   = read_port(rs1_addr, regs_q[rs1_addr], st_valid_q, st_rd_q, st_data_q);
    assign rs2_data   = read_port(rs2_addr, regs_q[rs2_addr], st_valid_q, st_rd_q, st_data_q);
    assign wr_pending = st_valid_q;

endmodule

// File: tb/tb_regfile_wb_bank.sv
// Scoreboard bench for regfile_wb_bank against an architectural register model.
module tb_regfile_wb_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wr_pending;

    regfile_wb_bank dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wr_pending (wr_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pend;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_reg [32];
    logic        model_pend;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one clock edge; the model updates architecturally at that edge.
    task automatic step(input logic r, input logic we, input logic [4:0] rd, input logic [31:0] d);
        rst     = r;
        wb_we   = we;
        wb_rd   = rd;
        wb_data = d;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) model_reg[i] = '0;
            model_pend = 1'b0;
        end else begin
            model_pend = we && (rd != 5'd0);
            if (model_pend) model_reg[rd] = d;
        end
        rst   = 1'b0;
        wb_we = 1'b0;
    endtask

    task automatic check_reads(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        exp_t g;
        rs1_addr = a1;
        rs2_addr = a2;
        e.rs1  = model_reg[a1];
        e.rs2  = model_reg[a2];
        e.pend = model_pend;
        sb_q.push_back(e);
        #1;
        g = sb_q.pop_front();
        check_eq({tag, ".rs1"}, rs1_data, g.rs1);
        check_eq({tag, ".rs2"}, rs2_data, g.rs2);
        check_eq({tag, ".pend"}, {31'd0, wr_pending}, {31'd0, g.pend});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model_reg[i] = '0;
        model_pend = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        step(1'b1, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0);
        check_reads("init", 5'd1, 5'd31);

        // Preload random values, then reset with a write request asserted.
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), $urandom);
        end
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check_reads("preload", 5'd3, 5'd30);
        step(1'b1, 1'b1, 5'd4, 32'hCAFE_F00D);
        for (int i = 1; i < 32; i++) begin
            check_reads("rst_clear", 5'(i), 5'(32 - i));
            step(1'b0, 1'b0, 5'd0, 32'd0);
        end

        // Basic write: bypass then array.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        check_reads("wr5_bypass", 5'd5, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check_reads("wr5_array", 5'd5, 5'd5);

        // x0 protection.
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check_reads("x0_a", 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check_reads("x0_b", 5'd0, 5'd0);

        // Back-to-back writes to the same rd.
        step(1'b0, 1'b1, 5'd7, 32'h1);
        check_reads("b2b_1", 5'd5, 5'd7);
        step(1'b0, 1'b1, 5'd7, 32'h2);
        check_reads("b2b_2", 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check_reads("b2b_3", 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check_reads("b2b_4", 5'd0, 5'd7);

        // Reset while a write is staged: it must never commit.
        step(1'b0, 1'b1, 5'd9, 32'h1234_5678);
        check_reads("mid_rst_byp", 5'd9, 5'd9);
        step(1'b1, 1'b0, 5'd0, 32'd0);
        check_reads("mid_rst_a", 5'd9, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'd0);
        check_reads("mid_rst_b", 5'd9, 5'd5);

        // Same-cycle wb inputs are not forwarded.
        wb_we   = 1'b1;
        wb_rd   = 5'd12;
        wb_data = 32'hAAAA_5555;
        check_reads("no_fwd", 5'd12, 5'd12);
        step(1'b0, 1'b1, 5'd12, 32'hAAAA_5555);
        check_reads("fwd_after", 5'd12, 5'd12);

        // Full sweep with consecutive writes and mid-stream reads.
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i));
            check_reads("sweep_wr", 5'(i), 5'((i + 31) % 32));
        end
        step(1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check_reads("sweep_rd", 5'(i), 5'(31 - i));
            check_reads("sweep_same", 5'(i), 5'(i));
            step(1'b0, 1'b0, 5'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_bank.md
# regfile_wb_bank

Integer register file for the 32-bit RISC-V core: 32 × 32-bit architectural registers with one staged write port and two read ports. The block sits downstream of the write-enable gating stage. The write-back request is latched for one cycle, decoded into a 32-bit one-hot enable mask (each bit is the decoded select AND the write enable), then committed to the array. Read ports forward the pending staged write so decode sees results without a bubble.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (x0..x31)
- AW, 5, register address width (log2 NREG)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wb_we  input  1  write-back request valid this cycle
- wb_rd  input  AW  destination register index
- wb_data  input  XLEN  write-back data
- rs1_addr  input  AW  read port 1 index
- rs2_addr  input  AW  read port 2 index
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_data  output  XLEN  read port 2 data (combinational)
- wr_pending  output  1  staged write is valid and not yet committed

## Operation
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Stage register holds `{st_valid, st_rd, st_data}`.
  - On each edge it loads `{wb_we && (wb_rd != 0), wb_rd, wb_data}`.
  - Writes to x0 are dropped at capture.
- Commit happens on the same edge.
  - If `st_valid`, then `reg[st_rd] <= st_data`.
  - The enable mask is `one_hot(st_rd) & {32{st_valid}}`; exactly 0 or 1 bit is set.
- x0 always reads 0. It has no storage, or its storage is never enabled.
- Read mux, evaluated per port:
  - If addr == 0: output 0.
  - Else if `st_valid` and addr == `st_rd`: output `st_data` (bypass).
  - Else: output `reg[addr]`.
- The bypass covers only the staged entry. Same-cycle `wb_*` inputs are not forwarded.
- Back-to-back writes to the same rd:
  - The older one commits while the newer one is captured.
  - The newer one wins on the following cycle.
  - The bypass always reflects the newest staged value.
- `wr_pending` = `st_valid`.
- Reset:
  - All 31 registers clear to 0.
  - `st_valid` clears to 0; a pending staged write is discarded and never commits.
  - `wb_we` asserted in the reset cycle is ignored.
- Reset values of outputs: `rs1_data` = `rs2_data` = 0 for every address, and `wr_pending` = 0.

## Timing
- Write latency:
  - Request sampled at edge N.
  - Visible through the bypass after edge N.
  - In the array after edge N+1.
  - Read data for that rd is correct from cycle N+1 onward, with no gap.
- Read latency: 0 cycles (combinational from addr and state).
- Throughput: one write per cycle, sustained; no backpressure, no stall input.
- Simultaneous reads of the same address on both ports return identical data.

## Structure
- Shared package `rv_core_pkg`:
  - `XLEN`, `NREG`, `AW`
  - typedefs `reg_addr_t` (logic [AW-1:0]) and `xword_t` (logic [XLEN-1:0])
  - constant `REG_ZERO` = 0
- One sub-module `wr_decode32`:
  - Function: 5-to-32 one-hot decoder with an enable input.
  - Output bit i = (addr == i) & en.
  - It produces the gated write-enable mask consumed by the array.
- Top level holds the stage register, the register array, and two instances of the read mux/bypass logic (a function or generate block, not a separate module).

## Test plan
- Reset:
  - Preload random values, assert `rst` one cycle.
  - All rs reads of x1..x31 → 0.
  - `wr_pending` = 0.
- Basic write/read:
  - wb x5 = 0xDEADBEEF at edge N.
  - rs1=5 after N → 0xDEADBEEF (bypass, `wr_pending`=1).
  - After N+1 → 0xDEADBEEF (array, `wr_pending`=0).
- x0 protection:
  - wb x0 = 0xFFFFFFFF.
  - `wr_pending` stays 0.
  - rs1=0 and rs2=0 → 0 in all following cycles.
- Back-to-back same rd:
  - wb x7 = 0x1 at N, then x7 = 0x2 at N+1.
  - rs2=7 → 0x1 after N.
  - rs2=7 → 0x2 after N+1 and thereafter.
- Reset mid-operation:
  - wb x9 = 0x12345678 at N, `rst` high at N+1.
  - rs1=9 → 0 after N+1; the write never commits.
- Full sweep:
  - Write x1..x31 with value = 0x100 + i on consecutive cycles.
  - Read all pairs on both ports.
  - Every read returns 0x100 + i; x0 returns 0.
